asu_ddr5_phase_serializer: RTL and testbench

//   Parametrised successor of the DFI frequency-ratio mapper in the DDR5 PHY write path.
//   - Captures one full DFI frame (up to pMAX_PHASES phases) into a shadow register at each frame boundary.
//   - Replays the frame one phase per clk_i cycle, giving ratio 1:1/1:2/1:4/1:8.
//   - Ratio changes and start/stop take effect only on frame boundaries.
//   - Drives DRAM-safe idle values when stopped.

---
 rtl/asu_ddr5_pkg.sv | 30 +++
 rtl/asu_ddr5_phase_mux.sv | 43 ++++
 rtl/asu_ddr5_phase_serializer.sv | 156 +++++++++++++++
 tb/tb_asu_ddr5_phase_serializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/asu_ddr5_pkg.sv
// Shared types and idle constants for the DDR5 DFI phase serializer.
package asu_ddr5_pkg;

  typedef enum logic [1:0] {
    R1_1 = 2'd0,
    R1_2 = 2'd1,
    R1_4 = 2'd2,
    R1_8 = 2'd3
  } ratio_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ser_state_e;

  localparam logic IDLE_CS_N    = 1'b1;
  localparam logic IDLE_RESET_N = 1'b0;

  // Last phase index of a frame; ratios wider than the shadow clamp to its depth.
  function automatic logic [2:0] ratio_last(input logic [1:0] ratio, input int unsigned max_phases);
    int unsigned span;
    span = 32'd1 << ratio;
    if (span > max_phases) begin
      ratio_last = 3'(max_phases - 32'd1);
    end else begin
      ratio_last = 3'(span - 32'd1);
    end
  endfunction

endpackage

// File: rtl/asu_ddr5_phase_mux.sv
// One DFI bus lane: frame shadow register plus the registered phase-select output.
module asu_ddr5_phase_mux #(
  parameter int pWIDTH      = 1,
  parameter int pMAX_PHASES = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                load_i,
  input  logic                                run_i,
  input  logic [$clog2(pMAX_PHASES)-1:0]      sel_i,
  input  logic [pMAX_PHASES*pWIDTH-1:0]       data_i,
  input  logic [pWIDTH-1:0]                   idle_i,
  output logic [pWIDTH-1:0]                   data_o
);

  logic [pMAX_PHASES*pWIDTH-1:0] shadow_r;
  logic [pWIDTH-1:0]             phase_s [pMAX_PHASES];

  for (genvar p = 0; p < pMAX_PHASES; p++) begin : g_phase
    assign phase_s[p] = shadow_r[p*pWIDTH +: pWIDTH];
  end

  // Frame capture at each load edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_r <= '0;
    end else if (load_i) begin
      shadow_r <= data_i;
    end
  end

  // Serial output: selected phase while running, DRAM-safe idle value otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= idle_i;
    end else if (run_i) begin
      data_o <= phase_s[sel_i];
    end else begin
      data_o <= idle_i;
    end
  end

endmodule

// File: rtl/asu_ddr5_phase_serializer.sv
// DFI frequency-ratio serializer: captures a DFI frame and replays it one phase per clock.
// Optional sticky ratio-error flag built only when ASU_DDR5_FR_RATIO_ERR_EN is defined.
module asu_ddr5_phase_serializer
  import asu_ddr5_pkg::*;
#(
  parameter int pNUM_RANK   = 2,
  parameter int pDRAM_SIZE  = 4,
  parameter int pADDR_W     = 14,
  parameter int pMAX_PHASES = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 enable_i,
  input  logic [1:0]                           dfi_freq_ratio_i,
  input  logic [pMAX_PHASES*pNUM_RANK-1:0]     dfi_cs_n_i,
  input  logic [pMAX_PHASES*pNUM_RANK-1:0]     dfi_reset_n_i,
  input  logic [pMAX_PHASES*pADDR_W-1:0]       dfi_address_i,
  input  logic [pMAX_PHASES-1:0]               dfi_wrdata_en_i,
  input  logic [pMAX_PHASES*2*pDRAM_SIZE-1:0]  dfi_wrdata_i,
  input  logic [pMAX_PHASES*pDRAM_SIZE/4-1:0]  dfi_wrdata_mask_i,
  output logic                                 load_o,
  output logic [pNUM_RANK-1:0]                 dfi_cs_n_o,
  output logic [pNUM_RANK-1:0]                 dfi_reset_n_o,
  output logic [pADDR_W-1:0]                   dfi_address_o,
  output logic                                 dfi_wrdata_en_o,
  output logic [2*pDRAM_SIZE-1:0]              dfi_wrdata_o,
  output logic [pDRAM_SIZE/4-1:0]              dfi_wrdata_mask_o,
  output logic [2:0]                           phase_o,
  output logic                                 frame_start_o,
  output logic                                 busy_o,
  output logic                                 ratio_err_o
);

  localparam int SEL_W  = $clog2(pMAX_PHASES);
  localparam int DATA_W = 2*pDRAM_SIZE;
  localparam int MASK_W = pDRAM_SIZE/4;

  ser_state_e state_r, state_nxt_s;
  ratio_e     ratio_r;
  logic [2:0] cnt_r, cnt_nxt_s, last_s, phase_r;
  logic       load_s, run_s, at_last_s, frame_start_r;

  assign last_s    = ratio_last(ratio_r, pMAX_PHASES);
  assign at_last_s = (cnt_r == last_s);
  assign run_s     = (state_r == RUN);
  assign load_o    = load_s;
  assign busy_o    = run_s;
  assign phase_o   = phase_r;
  assign frame_start_o = frame_start_r;

  // Next-state, counter and frame-load decode; enable only matters on frame boundaries.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = 3'd0;
        if (enable_i) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (at_last_s) begin
          cnt_nxt_s = 3'd0;
          if (enable_i) begin
            load_s      = 1'b1;
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // State, counter, frame ratio and phase/frame-start output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      cnt_r         <= 3'd0;
      ratio_r       <= R1_1;
      phase_r       <= 3'd0;
      frame_start_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (load_s) begin
        ratio_r <= ratio_e'(dfi_freq_ratio_i);
      end
      if (run_s) begin
        phase_r       <= cnt_r;
        frame_start_r <= (cnt_r == 3'd0);
      end else begin
        phase_r       <= 3'd0;
        frame_start_r <= 1'b0;
      end
    end
  end

  asu_ddr5_phase_mux #(.pWIDTH(pNUM_RANK), .pMAX_PHASES(pMAX_PHASES)) u_cs_n (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_s), .run_i(run_s), .sel_i(cnt_r[SEL_W-1:0]),
    .data_i(dfi_cs_n_i), .idle_i({pNUM_RANK{IDLE_CS_N}}), .data_o(dfi_cs_n_o));

  asu_ddr5_phase_mux #(.pWIDTH(pNUM_RANK), .pMAX_PHASES(pMAX_PHASES)) u_reset_n (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_s), .run_i(run_s), .sel_i(cnt_r[SEL_W-1:0]),
    .data_i(dfi_reset_n_i), .idle_i({pNUM_RANK{IDLE_RESET_N}}), .data_o(dfi_reset_n_o));

  asu_ddr5_phase_mux #(.pWIDTH(pADDR_W), .pMAX_PHASES(pMAX_PHASES)) u_address (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_s), .run_i(run_s), .sel_i(cnt_r[SEL_W-1:0]),
    .data_i(dfi_address_i), .idle_i({pADDR_W{1'b0}}), .data_o(dfi_address_o));

  asu_ddr5_phase_mux #(.pWIDTH(1), .pMAX_PHASES(pMAX_PHASES)) u_wrdata_en (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_s), .run_i(run_s), .sel_i(cnt_r[SEL_W-1:0]),
    .data_i(dfi_wrdata_en_i), .idle_i(1'b0), .data_o(dfi_wrdata_en_o));

  asu_ddr5_phase_mux #(.pWIDTH(DATA_W), .pMAX_PHASES(pMAX_PHASES)) u_wrdata (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_s), .run_i(run_s), .sel_i(cnt_r[SEL_W-1:0]),
    .data_i(dfi_wrdata_i), .idle_i({DATA_W{1'b0}}), .data_o(dfi_wrdata_o));

  asu_ddr5_phase_mux #(.pWIDTH(MASK_W), .pMAX_PHASES(pMAX_PHASES)) u_wrdata_mask (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_s), .run_i(run_s), .sel_i(cnt_r[SEL_W-1:0]),
    .data_i(dfi_wrdata_mask_i), .idle_i({MASK_W{1'b0}}), .data_o(dfi_wrdata_mask_o));

`ifdef ASU_DDR5_FR_RATIO_ERR_EN
  logic ratio_err_r;
  logic ratio_err_set_s;

  // A mid-frame ratio change, or a 1:8 request the shadow cannot hold, is flagged.
  assign ratio_err_set_s = (run_s && !load_s && (dfi_freq_ratio_i != ratio_r)) ||
                           (load_s && (dfi_freq_ratio_i == R1_8) && (pMAX_PHASES < 8));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ratio_err_r <= 1'b0;
    end else if (ratio_err_set_s) begin
      ratio_err_r <= 1'b1;
    end
  end

  assign ratio_err_o = ratio_err_r;
`else
  assign ratio_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_asu_ddr5_phase_serializer.sv
// Directed scoreboard bench for asu_ddr5_phase_serializer (4-phase and 8-phase instances).
module tb_asu_ddr5_phase_serializer;

  typedef struct {
    int          cyc;
    logic [13:0] addr;
    logic [1:0]  cs;
    logic [1:0]  rstn;
    logic        wren;
    logic [7:0]  wd;
    logic        mask;
    logic [2:0]  phase;
    logic        fs;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, en8;
  logic [1:0]   ratio, ratio8;
  logic [7:0]   cs_in, rstn_in;
  logic [55:0]  addr_in;
  logic [3:0]   wren_in, mask_in;
  logic [31:0]  wd_in;
  logic [111:0] addr8;

  logic        load_o, busy_o, fs_o, err_o, wren_o;
  logic [1:0]  cs_o, rstn_o;
  logic [13:0] addr_o;
  logic [7:0]  wd_o;
  logic [0:0]  mask_o;
  logic [2:0]  phase_o;

  logic        load8, busy8, fs8, err8, wren8;
  logic [1:0]  cs8, rstn8;
  logic [13:0] addr8_o;
  logic [7:0]  wd8;
  logic [0:0]  mask8;
  logic [2:0]  phase8;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  ent_t qa[$];
  ent_t qb[$];

  asu_ddr5_phase_serializer #(.pNUM_RANK(2), .pDRAM_SIZE(4), .pADDR_W(14), .pMAX_PHASES(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .dfi_freq_ratio_i(ratio),
    .dfi_cs_n_i(cs_in), .dfi_reset_n_i(rstn_in), .dfi_address_i(addr_in),
    .dfi_wrdata_en_i(wren_in), .dfi_wrdata_i(wd_in), .dfi_wrdata_mask_i(mask_in),
    .load_o(load_o), .dfi_cs_n_o(cs_o), .dfi_reset_n_o(rstn_o), .dfi_address_o(addr_o),
    .dfi_wrdata_en_o(wren_o), .dfi_wrdata_o(wd_o), .dfi_wrdata_mask_o(mask_o),
    .phase_o(phase_o), .frame_start_o(fs_o), .busy_o(busy_o), .ratio_err_o(err_o));

  asu_ddr5_phase_serializer #(.pNUM_RANK(2), .pDRAM_SIZE(4), .pADDR_W(14), .pMAX_PHASES(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .enable_i(en8), .dfi_freq_ratio_i(ratio8),
    .dfi_cs_n_i({16{1'b1}}), .dfi_reset_n_i({16{1'b1}}), .dfi_address_i(addr8),
    .dfi_wrdata_en_i(8'h00), .dfi_wrdata_i(64'h0), .dfi_wrdata_mask_i(8'h00),
    .load_o(load8), .dfi_cs_n_o(cs8), .dfi_reset_n_o(rstn8), .dfi_address_o(addr8_o),
    .dfi_wrdata_en_o(wren8), .dfi_wrdata_o(wd8), .dfi_wrdata_mask_o(mask8),
    .phase_o(phase8), .frame_start_o(fs8), .busy_o(busy8), .ratio_err_o(err8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected phases of a frame loaded in the current cycle on the 4-phase DUT.
  task automatic push_frame(input int n);
    ent_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc  = cyc + 2 + k;
      e.addr = addr_in[k*14 +: 14];
      e.cs   = cs_in[k*2 +: 2];
      e.rstn = rstn_in[k*2 +: 2];
      e.wren = wren_in[k];
      e.wd   = wd_in[k*8 +: 8];
      e.mask = mask_in[k];
      e.phase = 3'(k);
      e.fs   = (k == 0);
      qa.push_back(e);
    end
  endtask

  task automatic push_idle(input int c);
    ent_t e;
    e.cyc = c; e.addr = 14'h0; e.cs = 2'b11; e.rstn = 2'b00; e.wren = 1'b0;
    e.wd = 8'h00; e.mask = 1'b0; e.phase = 3'd0; e.fs = 1'b0;
    qa.push_back(e);
  endtask

  task automatic push_frame8();
    ent_t e;
    for (int k = 0; k < 8; k++) begin
      e.cyc = cyc + 2 + k; e.addr = addr8[k*14 +: 14]; e.phase = 3'(k); e.fs = (k == 0);
      e.cs = 2'b11; e.rstn = 2'b11; e.wren = 1'b0; e.wd = 8'h00; e.mask = 1'b0;
      qb.push_back(e);
    end
  endtask

  // One clock cycle: check at the falling edge, then advance just past the rising edge.
  task automatic step(input logic exp_load, input logic exp_busy);
    ent_t e;
    @(negedge clk);
    chk($sformatf("load_o@%0d", cyc), 64'(load_o), 64'(exp_load));
    chk($sformatf("busy_o@%0d", cyc), 64'(busy_o), 64'(exp_busy));
    while (qa.size() > 0 && qa[0].cyc == cyc) begin
      e = qa.pop_front();
      chk($sformatf("address@%0d", cyc), 64'(addr_o), 64'(e.addr));
      chk($sformatf("cs_n@%0d", cyc), 64'(cs_o), 64'(e.cs));
      chk($sformatf("reset_n@%0d", cyc), 64'(rstn_o), 64'(e.rstn));
      chk($sformatf("wrdata_en@%0d", cyc), 64'(wren_o), 64'(e.wren));
      chk($sformatf("wrdata@%0d", cyc), 64'(wd_o), 64'(e.wd));
      chk($sformatf("mask@%0d", cyc), 64'(mask_o), 64'(e.mask));
      chk($sformatf("phase@%0d", cyc), 64'(phase_o), 64'(e.phase));
      chk($sformatf("frame_start@%0d", cyc), 64'(fs_o), 64'(e.fs));
    end
    while (qb.size() > 0 && qb[0].cyc == cyc) begin
      e = qb.pop_front();
      chk($sformatf("p8_address@%0d", cyc), 64'(addr8_o), 64'(e.addr));
      chk($sformatf("p8_phase@%0d", cyc), 64'(phase8), 64'(e.phase));
      chk($sformatf("p8_frame_start@%0d", cyc), 64'(fs8), 64'(e.fs));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    ent_t e8;
    int   c;
    rst = 1'b1; en = 1'b0; en8 = 1'b0; ratio = 2'd0; ratio8 = 2'd0;
    cs_in = 8'b01_10_01_10; rstn_in = 8'hFF; addr_in = '0; addr8 = '0;
    wren_in = 4'b0101; mask_in = 4'b1010; wd_in = 32'h4433_2211;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;

    // Reset values.
    push_idle(cyc); step(1'b0, 1'b0);
    rst = 1'b0;
    push_idle(cyc); step(1'b0, 1'b0);
    chk("ratio_err_reset", 64'(err_o), 64'd0);

    // 1:4, enable held: two back-to-back frames, then enable dropped at cnt=1.
    en = 1'b1; ratio = 2'd2; addr_in = {14'h044, 14'h033, 14'h022, 14'h011};
    push_frame(4); step(1'b1, 1'b0);
    addr_in = '1;
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    addr_in = {14'h088, 14'h077, 14'h066, 14'h055}; wd_in = 32'h8877_6655;
    push_frame(4); step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    en = 1'b0;
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    push_idle(cyc + 1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Reset at cnt=2 of a 1:4 frame aborts the remaining phases.
    en = 1'b1; ratio = 2'd2; addr_in = {14'h0DD, 14'h0CC, 14'h0BB, 14'h0AA};
    push_frame(2); step(1'b1, 1'b0);
    en = 1'b0;
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    push_idle(cyc); push_idle(cyc + 1); push_idle(cyc + 2);
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);

    // 1:2 -> 1:4 change at cnt=0 applies from the next frame.
    en = 1'b1; ratio = 2'd1; addr_in = {14'h000, 14'h000, 14'h1B2, 14'h1A1};
    push_frame(2); step(1'b1, 1'b0);
    ratio = 2'd2;
    step(1'b0, 1'b1);
    addr_in = {14'h2D4, 14'h2C3, 14'h2B2, 14'h2A1};
    push_frame(4); step(1'b1, 1'b1);
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    en = 1'b0;
    push_idle(cyc + 2); step(1'b0, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
`ifdef ASU_DDR5_FR_RATIO_ERR_EN
    chk("ratio_err_midframe", 64'(err_o), 64'd1);
`else
    chk("ratio_err_tied", 64'(err_o), 64'd0);
`endif

    // 1:1 with wrdata_en phase 0 toggling 1,0,1.
    ratio = 2'd0; en = 1'b1; wren_in = 4'b0001;
    push_frame(1); step(1'b1, 1'b0);
    wren_in = 4'b0000;
    push_frame(1); step(1'b1, 1'b1);
    wren_in = 4'b0001;
    push_frame(1); step(1'b1, 1'b1);
    en = 1'b0;
    push_idle(cyc + 2); step(1'b0, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);

    // Ratio 3: clamped to 4 phases on the 4-phase DUT, 8 back-to-back phases on the 8-phase DUT.
    c = cyc;
    en = 1'b1; ratio = 2'd3; addr_in = {14'h3D4, 14'h3C3, 14'h3B2, 14'h3A1};
    push_frame(4); push_idle(c + 6); push_idle(c + 7);
    en8 = 1'b1; ratio8 = 2'd3;
    for (int k = 0; k < 8; k++) addr8[k*14 +: 14] = 14'h100 + 14'(k);
    push_frame8();
    for (int i = 0; i < 19; i++) begin
      if (i == 1) en = 1'b0;
      if (i == 8) begin
        for (int k = 0; k < 8; k++) addr8[k*14 +: 14] = 14'h200 + 14'(k);
        push_frame8();
        e8.cyc = c + 18; e8.addr = 14'h0; e8.phase = 3'd0; e8.fs = 1'b0;
        e8.cs = 2'b11; e8.rstn = 2'b00; e8.wren = 1'b0; e8.wd = 8'h00; e8.mask = 1'b0;
        qb.push_back(e8);
        #1 chk("p8_load_b2b", 64'(load8), 64'd1);
      end
      if (i == 10) en8 = 1'b0;
      if (i == 16) begin
        #1 chk("p8_load_stop", 64'(load8), 64'd0);
      end
      step(i == 0, (i >= 1) && (i <= 4));
    end

    chk("scoreboard_a_drained", 64'(qa.size()), 64'd0);
    chk("scoreboard_b_drained", 64'(qb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
